uart_tanh_sequencer: RTL and testbench

Frame-level controller between the basic_uart byte interface and the CORDIC tanh core. It collects a framed operand from UART receive bytes, starts the core, and waits for its result. It then serialises a framed response back through the UART transmitter using the tx_enable/tx_ready handshake. This replaces the plain loopback FSM in the serial top level.

---
 rtl/uart_tanh_sequencer_pkg.sv | 7 +
 rtl/uart_tanh_sequencer_if.sv | 22 ++
 rtl/uart_tanh_sequencer_timeout_counter.sv | 19 +
 rtl/uart_tanh_sequencer.sv | 117 +++++++++++
 tb/tb_uart_tanh_sequencer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_tanh_sequencer_pkg.sv
// tanh_uart_pkg: state encoding and framing bytes shared by the tanh UART sequencer.
package tanh_uart_pkg;
   typedef enum logic [2:0] {IDLE, RX_OP, START, WAIT_CORE, TX_SEND, TX_GAP} state_e;
   localparam logic [7:0] HDR_REQ = 8'hA5;
   localparam logic [7:0] HDR_RSP = 8'h5A;
   localparam logic [7:0] NAK     = 8'h15;
endpackage

// File: rtl/uart_tanh_sequencer_if.sv
// uart_tanh_sequencer_if: UART byte handshake and tanh core signals seen by the sequencer.
interface uart_tanh_sequencer_if #(parameter int DATA_W = 16);
   logic [7:0]        rx_data;
   logic              rx_enable;
   logic [7:0]        tx_data;
   logic              tx_enable;
   logic              tx_ready;
   logic              cordic_start;
   logic [DATA_W-1:0] cordic_x;
   logic              cordic_done;
   logic [DATA_W-1:0] cordic_result;
   logic              busy;
   logic [1:0]        err;
   modport master (
      input  rx_data, rx_enable, tx_ready, cordic_done, cordic_result,
      output tx_data, tx_enable, cordic_start, cordic_x, busy, err
   );
   modport slave (
      output rx_data, rx_enable, tx_ready, cordic_done, cordic_result,
      input  tx_data, tx_enable, cordic_start, cordic_x, busy, err
   );
endinterface

// File: rtl/uart_tanh_sequencer_timeout_counter.sv
// timeout_counter: saturating cycle counter with clear, enable and terminal-count flag.
module timeout_counter #(
   parameter int LIMIT = 4096
) (
   input  logic clk,
   input  logic resetn,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);
   localparam int W = $clog2(LIMIT) + 1;
   localparam logic [W-1:0] LIM = W'(LIMIT);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != LIM) ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) cnt_q <= '0;
      else cnt_q <= cnt_d;
   assign tc_o = cnt_q == LIM;
endmodule

// File: rtl/uart_tanh_sequencer.sv
// uart_tanh_sequencer: collects a framed operand from UART bytes, runs the tanh core,
// and serialises a framed result (or a NAK on core timeout) back out.
module uart_tanh_sequencer
   import tanh_uart_pkg::*;
#(
   parameter int DATA_W       = 16,
   parameter int RX_TIMEOUT   = 100000,
   parameter int CORE_TIMEOUT = 4096
) (
   input logic clk,
   input logic resetn,
   uart_tanh_sequencer_if.master bus
);
   localparam int NB = DATA_W / 8;
   localparam int BW = $clog2(NB + 1);
   localparam int TW = $clog2(NB + 2);
   localparam logic [BW-1:0] LAST_B = BW'(NB - 1);
   localparam logic [TW-1:0] LAST_T = TW'(NB + 1);

   state_e            state_q, state_d;
   logic [BW-1:0]     byte_cnt_q, byte_cnt_d;
   logic [TW-1:0]     tx_idx_q, tx_idx_d;
   logic [DATA_W-1:0] x_q, x_d, res_q, res_d;
   logic              nak_q, nak_d;
   logic [1:0]        err_q, err_d;
   logic              rx_tc, core_tc, tx_en;
   logic [7:0]        cur_byte;

   timeout_counter #(.LIMIT(RX_TIMEOUT)) u_rx_to (
      .clk(clk), .resetn(resetn),
      .clr_i(state_q != RX_OP || bus.rx_enable), .en_i(state_q == RX_OP), .tc_o(rx_tc)
   );

   timeout_counter #(.LIMIT(CORE_TIMEOUT)) u_core_to (
      .clk(clk), .resetn(resetn),
      .clr_i(state_q != WAIT_CORE), .en_i(state_q == WAIT_CORE), .tc_o(core_tc)
   );

   // Byte 0 is the header; result bytes leave from the top of the shift register.
   assign cur_byte = nak_q ? NAK : (tx_idx_q == '0) ? HDR_RSP : res_q[DATA_W-1 -: 8];

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      tx_idx_d   = tx_idx_q;
      x_d        = x_q;
      res_d      = res_q;
      nak_d      = nak_q;
      err_d      = err_q;
      tx_en      = 1'b0;
      case (state_q)
         IDLE:
            if (bus.rx_enable && bus.rx_data == HDR_REQ) begin
               state_d    = RX_OP;
               byte_cnt_d = '0;
               err_d      = '0;
            end
         RX_OP:
            if (bus.rx_enable) begin
               x_d        = DATA_W'({x_q, bus.rx_data});
               byte_cnt_d = byte_cnt_q + 1'b1;
               state_d    = (byte_cnt_q == LAST_B) ? START : RX_OP;
            end else if (rx_tc) begin
               state_d  = IDLE;
               err_d[0] = 1'b1;
            end
         START: state_d = WAIT_CORE;
         WAIT_CORE:
            if (bus.cordic_done) begin
               res_d    = bus.cordic_result;
               tx_idx_d = '0;
               nak_d    = 1'b0;
               state_d  = TX_SEND;
            end else if (core_tc) begin
               err_d[1] = 1'b1;
               tx_idx_d = '0;
               nak_d    = 1'b1;
               state_d  = TX_SEND;
            end
         TX_SEND:
            if (bus.tx_ready) begin
               tx_en    = 1'b1;
               tx_idx_d = tx_idx_q + 1'b1;
               res_d    = (tx_idx_q == '0) ? res_q : res_q << 8;
               state_d  = TX_GAP;
            end
         TX_GAP: state_d = (nak_q || tx_idx_q == LAST_T) ? IDLE : TX_SEND;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         state_q    <= IDLE;
         byte_cnt_q <= '0;
         tx_idx_q   <= '0;
         x_q        <= '0;
         res_q      <= '0;
         nak_q      <= 1'b0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         tx_idx_q   <= tx_idx_d;
         x_q        <= x_d;
         res_q      <= res_d;
         nak_q      <= nak_d;
         err_q      <= err_d;
      end

   assign bus.tx_enable    = tx_en;
   assign bus.tx_data      = (state_q == TX_SEND) ? cur_byte : 8'h00;
   assign bus.cordic_start = state_q == START;
   assign bus.cordic_x     = x_q;
   assign bus.busy         = state_q != IDLE;
   assign bus.err          = err_q;
endmodule

// File: tb/tb_uart_tanh_sequencer.sv
// tb_uart_tanh_sequencer: randomized frames against a byte-list reference model of the sequencer.
module tb_uart_tanh_sequencer;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   n_cmp = 0, n_bad = 0, n_start = 0, cyc = 0, last_tx = -100, ub = 0;
   bit   bp_hold = 1'b0;
   logic [7:0] got_q[$];

   uart_tanh_sequencer_if #(.DATA_W(16)) bus ();

   uart_tanh_sequencer #(.DATA_W(16), .RX_TIMEOUT(20), .CORE_TIMEOUT(30)) dut (
      .clk(clk), .resetn(resetn), .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Transmit and start monitor
   always @(negedge clk)
      if (resetn) begin
         if (bus.cordic_start) n_start++;
         if (bus.tx_enable) begin
            check("tx_ready_at_pulse", 32'(bus.tx_ready), 1);
            check("tx_pulse_spacing", 32'((cyc - last_tx) >= 2), 1);
            last_tx = cyc;
            got_q.push_back(bus.tx_data);
         end
      end

   // Simple basic_uart transmitter: busy for a few cycles after each tx_enable
   initial begin
      bus.tx_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (resetn && bus.tx_enable) ub = $urandom_range(1, 4);
         @(posedge clk);
         #1;
         bus.tx_ready = !bp_hold && ub == 0;
         if (ub > 0) ub--;
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_data   = b;
      bus.rx_enable = 1'b1;
      @(posedge clk);
      #1;
      bus.rx_enable = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (bus.busy && k < 300);
      check("idle_reached", 32'(bus.busy), 0);
   endtask

   // lat < 0 means the core never answers
   task automatic run_txn(input logic [15:0] op, input logic [15:0] res, input int lat,
                          input int bp, input bit junk_wait);
      logic [7:0] exp_q[$];
      logic [1:0] exp_err;
      int n0 = n_start;
      send_byte(8'hA5);
      idle($urandom_range(0, 3));
      send_byte(op[15:8]);
      idle($urandom_range(0, 3));
      send_byte(op[7:0]);
      @(negedge clk);
      check("start_after_last_byte", 32'(bus.cordic_start), 1);
      check("cordic_x", 32'(bus.cordic_x), 32'(op));
      check("busy_in_frame", 32'(bus.busy), 1);
      check("err_cleared", 32'(bus.err), 0);
      bp_hold = bp > 0 && lat >= 0;
      @(posedge clk);
      #1;
      check("start_one_cycle", 32'(bus.cordic_start), 0);
      if (lat >= 0) begin
         for (int i = 0; i < lat; i++) begin
            bus.rx_data   = 8'hA5;
            bus.rx_enable = junk_wait && i == 0;
            @(posedge clk);
            #1;
         end
         bus.rx_enable     = 1'b0;
         bus.cordic_result = res;
         bus.cordic_done   = 1'b1;
         @(posedge clk);
         #1;
         bus.cordic_done = 1'b0;
         idle(bp);
         check("no_tx_under_backpressure", 32'(got_q.size()), 0);
         bp_hold = 1'b0;
         exp_q   = '{8'h5A, res[15:8], res[7:0]};
         exp_err = 2'b00;
      end else begin
         exp_q   = '{8'h15};
         exp_err = 2'b10;
      end
      wait_idle();
      check("tx_byte_count", 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("tx_byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
      check("err_after_frame", 32'(bus.err), 32'(exp_err));
      check("one_start_per_frame", 32'(n_start), 32'(n0 + 1));
      if (lat < 0) begin
         bus.cordic_done = 1'b1;
         idle(1);
         bus.cordic_done = 1'b0;
         idle(10);
         check("late_done_ignored", 32'(got_q.size()), 1);
         check("late_done_busy", 32'(bus.busy), 0);
      end
      got_q.delete();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n0;
      bus.rx_data = 8'h00;
      bus.rx_enable = 1'b0;
      bus.cordic_done = 1'b0;
      bus.cordic_result = '0;
      @(negedge clk);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_err", 32'(bus.err), 0);
      check("rst_tx_enable", 32'(bus.tx_enable), 0);
      check("rst_tx_data", 32'(bus.tx_data), 0);
      check("rst_cordic_start", 32'(bus.cordic_start), 0);
      check("rst_cordic_x", 32'(bus.cordic_x), 0);
      idle(2);
      resetn = 1'b1;
      idle(2);
      // Normal frame, backpressured frame, junk plus a byte during WAIT_CORE
      run_txn(16'h1234, 16'h0BEE, 3, 0, 1'b0);
      run_txn(16'h1234, 16'h0BEE, 0, 50, 1'b0);
      send_byte(8'h00);
      send_byte(8'hFF);
      run_txn(16'hA5A5, 16'h7FFF, 6, 0, 1'b1);
      // Inter-byte timeout drops the partial frame
      n0 = n_start;
      send_byte(8'hA5);
      send_byte(8'h12);
      idle(25);
      @(negedge clk);
      check("rx_to_idle", 32'(bus.busy), 0);
      check("rx_to_err", 32'(bus.err), 1);
      check("rx_to_no_start", 32'(n_start), 32'(n0));
      run_txn(16'h0080, 16'h0040, 2, 0, 1'b0);
      // Core timeout gives a NAK
      run_txn(16'h4000, 16'h0000, -1, 0, 1'b0);
      for (int t = 0; t < 12; t++) begin
         int j = $urandom_range(0, 2);
         for (int i = 0; i < j; i++) begin
            logic [7:0] b = 8'($urandom);
            send_byte(b == 8'hA5 ? 8'h00 : b);
         end
         run_txn(16'($urandom), 16'($urandom),
                 $urandom_range(0, 3) == 0 ? -1 : int'($urandom_range(0, 20)),
                 $urandom_range(0, 1) ? int'($urandom_range(1, 15)) : 0,
                 1'($urandom_range(0, 1)));
      end
      // Reset right after the response header leaves
      send_byte(8'hA5);
      send_byte(8'hBE);
      send_byte(8'hEF);
      idle(2);
      bus.cordic_result = 16'h0BEE;
      bus.cordic_done = 1'b1;
      idle(1);
      bus.cordic_done = 1'b0;
      for (int k = 0; k < 50 && got_q.size() == 0; k++) @(negedge clk);
      check("hdr_before_reset", 32'(got_q.size() > 0 ? got_q[0] : 8'h00), 32'h5A);
      resetn = 1'b0;
      #1;
      check("mid_rst_tx_enable", 32'(bus.tx_enable), 0);
      check("mid_rst_busy", 32'(bus.busy), 0);
      check("mid_rst_tx_data", 32'(bus.tx_data), 0);
      check("mid_rst_err", 32'(bus.err), 0);
      idle(3);
      resetn = 1'b1;
      idle(30);
      check("no_tx_after_reset", 32'(got_q.size()), 1);
      check("idle_after_reset", 32'(bus.busy), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
